// File: rtl/riscv_chk_pkg.sv
// riscv_chk_pkg: shared types and constants for the RV64I result checker
package riscv_chk_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, WAIT_CLR} chk_state_e;

    localparam int REC_TW   = 16;
    localparam int REC_CHW  = 3;
    localparam int REC_XLEN = 64;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef struct packed {
        logic [REC_TW-1:0]   test;
        logic [REC_CHW-1:0]  ch;
        logic [REC_XLEN-1:0] exp;
        logic [REC_XLEN-1:0] act;
    } chk_rec_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/chk_fifo.sv
// chk_fifo: first-word-fall-through synchronous FIFO, power-of-two depth
module chk_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_cnt;
    logic             w_do_push, w_do_pop;

    assign empty     = r_cnt == '0;
    assign full      = r_cnt == (AW+1)'(DEPTH);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rp];

    // pointers and occupancy; a pop frees a slot for a same-cycle push when full
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // storage array, written only on accepted pushes
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/riscv_result_checker.sv
// riscv_result_checker: counts one pass/fail verdict per end-of-test marker and logs failures
module riscv_result_checker
    import riscv_chk_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              NCH         = 2,
    parameter longint unsigned MARK_VAL    = 1,
    parameter int              SETTLE_CYC  = 2,
    parameter int              LOG_DEPTH   = 4,
    parameter int unsigned     TIMEOUT_CYC = 100000,
    localparam int             CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [XLEN-1:0]     marker,
    input  logic [NCH*XLEN-1:0] exp_flat,
    input  logic [NCH*XLEN-1:0] act_flat,
    input  logic [NCH-1:0]      ch_en,
    output logic [15:0]         pass_cnt,
    output logic [15:0]         fail_cnt,
    output logic                busy,
    output logic                timeout,
    output logic                overflow,
    output logic                all_pass,
    output logic                log_valid,
    input  logic                log_ready,
    output logic [15:0]         log_test,
    output logic [CHW-1:0]      log_ch,
    output logic [XLEN-1:0]     log_exp,
    output logic [XLEN-1:0]     log_act
);
    chk_state_e      r_state, w_state_nxt;
    logic [31:0]     r_settle, w_settle_nxt;
    logic            r_mark_q;
    logic [15:0]     r_pass, r_fail;
    logic [31:0]     r_wd;
    logic            r_timeout, r_overflow;
    logic            w_match, w_rise, w_cmp, w_fail, w_full, w_empty;
    logic [NCH-1:0]  w_mis;
    logic [CHW-1:0]  w_lo;
    logic [XLEN-1:0] w_exp_sel, w_act_sel;
    chk_rec_t        w_rec, w_head;
    logic            w_unused_head;

    assign w_match = marker == XLEN'(MARK_VAL);
    assign w_rise  = w_match & ~r_mark_q;
    assign w_cmp   = r_state == COMPARE;
    assign w_fail  = w_cmp & (|w_mis);

    // state, settle counter and marker history
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_settle <= '0;
            r_mark_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
            r_mark_q <= w_match;
        end
    end

    // next state: a marker drop during settling cancels the test uncounted
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        unique case (r_state)
            IDLE: if (w_rise) begin
                w_state_nxt  = SETTLE;
                w_settle_nxt = 32'(SETTLE_CYC - 1);
            end
            SETTLE: begin
                if (!w_match) w_state_nxt = IDLE;
                else if (r_settle == '0) w_state_nxt = COMPARE;
                else w_settle_nxt = r_settle - 32'd1;
            end
            COMPARE:  w_state_nxt = WAIT_CLR;
            WAIT_CLR: w_state_nxt = w_match ? WAIT_CLR : IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // per-channel mismatch; descending scan leaves the lowest mismatching channel selected
    always_comb begin
        w_mis     = '0;
        w_lo      = '0;
        w_exp_sel = '0;
        w_act_sel = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            w_mis[i] = ch_en[i] & (exp_flat[i*XLEN +: XLEN] != act_flat[i*XLEN +: XLEN]);
            if (w_mis[i]) begin
                w_lo      = CHW'(i);
                w_exp_sel = exp_flat[i*XLEN +: XLEN];
                w_act_sel = act_flat[i*XLEN +: XLEN];
            end
        end
    end

    // verdict counters, sticky flags and watchdog
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pass     <= '0;
            r_fail     <= '0;
            r_wd       <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_cmp && !w_fail) r_pass <= sat_inc(r_pass);
            if (w_fail) r_fail <= sat_inc(r_fail);
            if (w_fail && w_full && !log_ready) r_overflow <= 1'b1;
            if (TIMEOUT_CYC != 0 && r_wd == TIMEOUT_CYC) r_timeout <= 1'b1;
            r_wd <= w_cmp ? '0 : r_wd + 32'd1;
        end
    end

    assign w_rec = '{test: r_pass + r_fail, ch: REC_CHW'(w_lo),
                     exp: REC_XLEN'(w_exp_sel), act: REC_XLEN'(w_act_sel)};

    chk_fifo #(.WIDTH($bits(chk_rec_t)), .DEPTH(LOG_DEPTH)) u_log (
        .clock (clock),
        .reset (reset),
        .push  (w_fail),
        .pop   (log_ready),
        .full  (w_full),
        .empty (w_empty),
        .din   (w_rec),
        .dout  (w_head)
    );

    assign w_unused_head = ^w_head;
    assign pass_cnt  = r_pass;
    assign fail_cnt  = r_fail;
    assign busy      = (r_state == SETTLE) || (r_state == COMPARE);
    assign timeout   = r_timeout;
    assign overflow  = r_overflow;
    assign all_pass  = (r_pass != '0) && (r_fail == '0) && !r_timeout;
    assign log_valid = ~w_empty;
    assign log_test  = w_empty ? '0 : w_head.test;
    assign log_ch    = w_empty ? '0 : CHW'(w_head.ch);
    assign log_exp   = w_empty ? '0 : XLEN'(w_head.exp);
    assign log_act   = w_empty ? '0 : XLEN'(w_head.act);

endmodule

// File: doc/riscv_result_checker.md
# riscv_result_checker

Synthesizable, self-checking result monitor for the RV64I core test flow. It watches a core-supplied end-of-test marker register and compares NCH expected/actual register pairs exactly once per test. It keeps saturating pass/fail counters, logs each failure into a small FIFO, and raises a sticky watchdog timeout. It sits beside the core in simulation and FPGA builds and replaces per-cycle print checking with a single counted verdict per test.

## Interface
Parameters:
- XLEN, 64, register width
- NCH, 2, number of compared register pairs (1..8)
- MARK_VAL, 1, marker value that signals end of test
- SETTLE_CYC, 2, cycles to wait after marker rise before sampling (≥1)
- LOG_DEPTH, 4, failure-log FIFO depth (power of two)
- TIMEOUT_CYC, 100000, watchdog limit in cycles (0 = disabled)

Ports (CHW = max(1, clog2(NCH))):
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- marker  in  XLEN  marker register value from the core
- exp_flat  in  NCH*XLEN  expected values; channel i is at [i*XLEN +: XLEN]
- act_flat  in  NCH*XLEN  actual values, same packing
- ch_en  in  NCH  per-channel compare enable
- pass_cnt  out  16  tests passed (saturates at 0xFFFF)
- fail_cnt  out  16  tests failed (saturates at 0xFFFF)
- busy  out  1  high in SETTLE or COMPARE
- timeout  out  1  sticky watchdog flag
- overflow  out  1  sticky; set when a failure record is dropped
- all_pass  out  1  pass_cnt≠0 & fail_cnt=0 & !timeout
- log_valid  out  1  failure FIFO not empty
- log_ready  in  1  pop the head record when log_valid is high
- log_test  out  16  test number of the head record (pass_cnt+fail_cnt before that test)
- log_ch  out  CHW  lowest mismatching enabled channel
- log_exp, log_act  out  XLEN  expected and actual values of that channel

## Operation
- match = (marker == MARK_VAL). mark_q is the registered match. rise = match & ~mark_q.
- FSM states and transitions:
  - IDLE: on rise, go to SETTLE and load settle_cnt = SETTLE_CYC−1.
  - SETTLE: decrement settle_cnt. At 0, go to COMPARE. If match drops, the rise was spurious: go to IDLE with no count.
  - COMPARE: one cycle. mis[i] = ch_en[i] & (exp_i ≠ act_i).
    - If mis = 0, pass_cnt++.
    - Otherwise fail_cnt++ and push {test number, lowest i with mis[i], exp_i, act_i} into the FIFO.
    - Go to WAIT_CLR.
  - WAIT_CLR: stay until match = 0, then go to IDLE. The marker held high is therefore counted once, not every cycle.
- ch_en = 0 counts as a pass.
- Counters saturate; they do not wrap.
- FIFO full on push: drop the record, set overflow. fail_cnt still increments.
- Push and pop in the same cycle when full: the pop occurs, the push is accepted, and overflow is not set.
- Watchdog: wd_cnt (32 bit) clears on reset and in every COMPARE cycle, and otherwise increments. When TIMEOUT_CYC≠0 and wd_cnt reaches TIMEOUT_CYC, timeout is set. timeout is cleared only by reset.
- Reset (including mid-test): state = IDLE, mark_q = 0, all counters 0, FIFO emptied, timeout = 0, overflow = 0.

## Timing
- Reset values: pass_cnt = 0, fail_cnt = 0, busy = 0, timeout = 0, overflow = 0, all_pass = 0, log_valid = 0. log_test, log_ch, log_exp, log_act = 0.
- rise is seen in cycle N:
  - SETTLE during N+1 .. N+SETTLE_CYC
  - COMPARE in N+SETTLE_CYC+1, with exp/act sampled in that cycle
  - counters and log_valid update at N+SETTLE_CYC+2
- Default SETTLE_CYC = 2: compare at N+3, counters visible at N+4.
- FIFO is first-word-fall-through. A pop takes effect on the edge where log_valid & log_ready is high. The next record (or log_valid = 0) is visible the following cycle.
- Marker falling and rising on back-to-back cycles in WAIT_CLR: the fall returns to IDLE, and the new rise is detected one cycle later.

## Structure
- Package riscv_chk_pkg holds:
  - the state enum chk_state_e {IDLE, SETTLE, COMPARE, WAIT_CLR}
  - the struct chk_rec_t {test, ch, exp, act} (parameterised widths via localparams)
  - the counter saturation constant CNT_MAX = 16'hFFFF
- Sub-module chk_fifo: generic synchronous FIFO with parameters WIDTH and DEPTH, ports push, pop, full, empty, din, dout, FWFT. The checker instantiates it for the log.

## Test plan
- Marker 0→1 held 20 cycles; exp = act = {5, 7}, ch_en = 2'b11 → pass_cnt = 1 at N+4, stays 1; fail_cnt = 0; all_pass = 1.
- exp = {5, 7}, act = {5, 9} → fail_cnt = 1; log_valid = 1 with log_test = 0, log_ch = 1, log_exp = 7, log_act = 9; pulse log_ready → log_valid = 0 the next cycle.
- Five failing tests, log_ready = 0, LOG_DEPTH = 4 → fail_cnt = 5, overflow = 1, four records with log_test = 0..3.
- Marker high for 1 cycle only (drops in SETTLE) → no count change, state back to IDLE. Mismatch on a disabled channel (ch_en = 2'b01) → pass.
- TIMEOUT_CYC = 50, no marker → timeout = 1 at cycle 50 and stays set after a later passing test; all_pass = 0.
- Assert reset in cycle N+2 of a pending failing test → all outputs at reset values next cycle; no record logged.
